// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while i_clear is high so every state entry starts a fresh bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_bit_end = !i_clear && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
// A held i_tx_start launches one frame; it must drop for a cycle to re-arm.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output logic                 o_tx
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS > 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  state_t                   r_state;
  logic [DATA_BITS-1:0]     r_shift;
  logic [BW-1:0]            r_bit_cnt;
  logic                     r_stop_cnt;
  logic                     r_armed;
  logic                     r_parity;
  logic                     r_tx;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_bit_end;
  logic                     w_accept;
  logic [MAX_DATA_BITS-1:0] w_data_ext;

  assign w_accept  = (r_state == IDLE) && i_tx_start && r_armed;
  assign o_tx      = r_tx;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

  always_comb begin
    w_data_ext                = '0;
    w_data_ext[DATA_BITS-1:0] = i_tx_data;
  end

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (r_state == IDLE),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_armed    <= 1'b1;
      r_parity   <= 1'b0;
      r_tx       <= LINE_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_armed <= 1'b0;
      end else if (!i_tx_start) begin
        r_armed <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift  <= i_tx_data;
            r_parity <= parity(w_data_ext, ODD);
            r_state  <= START;
            r_tx     <= LINE_START;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= STOP;
                r_tx    <= LINE_IDLE;
              end
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state    <= STOP;
            r_tx       <= LINE_IDLE;
            r_stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt == LAST_STOP) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two configurations (8N1 and 8O2) driven with the same stimulus,
// checked every cycle against a frame-level model plus hand-computed expectations.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] w_tx, w_busy, w_done;
  logic       cmp_en = 1'b0;

  int cfg_pen[2]   = '{0, 1};
  int cfg_podd[2]  = '{0, 1};
  int cfg_nstop[2] = '{1, 2};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(tx_start), .i_tx_data(tx_data),
    .o_tx_busy(w_busy[0]), .o_tx_done(w_done[0]), .o_tx(w_tx[0])
  );

  uart_tx #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(tx_start), .i_tx_data(tx_data),
    .o_tx_busy(w_busy[1]), .o_tx_done(w_done[1]), .o_tx(w_tx[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: start, data LSB first, parity or stop, then stop fill.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int pen, input int podd);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pen != 0) f[9] = (^d) ^ (podd != 0);
    return f;
  endfunction

  // Model: position within the current frame in cycles (-1 when idle).
  int          m_pos[2]   = '{-1, -1};
  int          m_len[2]   = '{10, 12};
  logic        m_armed[2] = '{1'b1, 1'b1};
  logic        m_done[2]  = '{1'b0, 1'b0};
  logic [11:0] m_bits[2]  = '{12'hfff, 12'hfff};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pos[k]   <= -1;
        m_armed[k] <= 1'b1;
        m_done[k]  <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_pos[k] >= 0) begin
          if (m_pos[k] + 1 == m_len[k] * C) begin
            m_pos[k]  <= -1;
            m_done[k] <= 1'b1;
          end else begin
            m_pos[k] <= m_pos[k] + 1;
          end
        end else if (tx_start && m_armed[k]) begin
          m_pos[k]   <= 0;
          m_armed[k] <= 1'b0;
          m_bits[k]  <= frame_bits(tx_data, cfg_pen[k], cfg_podd[k]);
          m_len[k]   <= 9 + cfg_pen[k] + cfg_nstop[k];
        end
        if (!tx_start) m_armed[k] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int exp_tx;
        exp_tx = (m_pos[k] < 0) ? 1 : int'(m_bits[k][m_pos[k] / C]);
        chk($sformatf("model_tx%0d", k), int'(w_tx[k]), exp_tx);
        chk($sformatf("model_busy%0d", k), int'(w_busy[k]), int'(m_pos[k] >= 0));
        chk($sformatf("model_done%0d", k), int'(w_done[k]), int'(m_done[k]));
      end
    end
  end

  // Capture window, one sample per falling edge starting at the current one.
  logic s_tx[2][256];
  logic s_busy[2][256];
  logic s_done[2][256];
  int   cnt_busy[2];
  int   cnt_done[2];

  task automatic run_window(input int n);
    for (int k = 0; k < 2; k++) begin
      cnt_busy[k] = 0;
      cnt_done[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        s_tx[k][i]   = w_tx[k];
        s_busy[k][i] = w_busy[k];
        s_done[k][i] = w_done[k];
        cnt_busy[k] += int'(w_busy[k]);
        cnt_done[k] += int'(w_done[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0]  pat10;
    logic [11:0] pat12;
    int          found;

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(w_tx[0]), 1);
    chk("reset_busy", int'(w_busy[0]), 0);
    chk("reset_done", int'(w_done[0]), 0);
    chk("reset_tx1", int'(w_tx[1]), 1);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic frame, A5, one-cycle request.
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    tx_start = 1'b0;
    run_window(52);
    pat10 = 10'b1_1010_0101_0;
    for (int b = 0; b < 10; b++) chk($sformatf("basic_bit%0d", b), int'(s_tx[0][b*C+2]), int'(pat10[b]));
    chk("basic_busy_cycles", cnt_busy[0], 40);
    chk("basic_done_count", cnt_done[0], 1);
    chk("basic_done_at_40", int'(s_done[0][40]), 1);
    chk("basic_busy_at_40", int'(s_busy[0][40]), 0);
    chk("basic_busy_cycles_8o2", cnt_busy[1], 48);

    // Parity and two stop bits, 07: odd parity of three ones is 0.
    tx_start = 1'b1;
    tx_data  = 8'h07;
    @(negedge clk);
    tx_start = 1'b0;
    run_window(52);
    pat12 = 12'b11_0_0000_0111_0;
    for (int b = 0; b < 12; b++) chk($sformatf("par_bit%0d", b), int'(s_tx[1][b*C+2]), int'(pat12[b]));
    chk("par_busy_cycles", cnt_busy[1], 48);
    chk("par_done_count", cnt_done[1], 1);
    chk("par_done_at_48", int'(s_done[1][48]), 1);

    // Held request: exactly one frame.
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    run_window(200);
    chk("held_done_count0", cnt_done[0], 1);
    chk("held_done_count1", cnt_done[1], 1);
    chk("held_busy_cycles0", cnt_busy[0], 40);
    chk("held_tx_idle_after", int'(s_tx[0][199]), 1);
    tx_start = 1'b0;
    @(negedge clk);

    // Back-to-back: drop the request mid-frame, raise it before the frame ends.
    tx_start = 1'b1;
    tx_data  = 8'h01;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h80;
    repeat (10) @(negedge clk);
    tx_start = 1'b1;
    run_window(120);
    tx_start = 1'b0;
    found = -1;
    for (int i = 0; i < 118; i++) if (found < 0 && s_done[0][i]) found = i;
    chk("b2b_first_done_idx", found, 30);
    if (found >= 0) begin
      chk("b2b_busy_low_in_done", int'(s_busy[0][found]), 0);
      chk("b2b_start_next_cycle", int'(s_tx[0][found+1]), 0);
      chk("b2b_busy_next_cycle", int'(s_busy[0][found+1]), 1);
      chk("b2b_second_bit7", int'(s_tx[0][found+1+8*C+2]), 1);
    end
    chk("b2b_done_count0", cnt_done[0], 2);
    chk("b2b_done_count1", cnt_done[1], 2);
    repeat (60) @(negedge clk);

    // Reset during the third data bit.
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (14) @(negedge clk);
    tx_start = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx0", int'(w_tx[0]), 1);
    chk("rst_mid_busy0", int'(w_busy[0]), 0);
    chk("rst_mid_tx1", int'(w_tx[1]), 1);
    chk("rst_mid_busy1", int'(w_busy[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart_tx0", int'(w_tx[0]), 0);
    chk("rst_restart_busy0", int'(w_busy[0]), 1);
    chk("rst_restart_tx1", int'(w_tx[1]), 0);
    tx_start = 1'b0;
    run_window(60);
    chk("rst_restart_done0", cnt_done[0], 1);

    // Ignored pulse and mid-frame data change.
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (8) @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h0F;
    run_window(70);
    chk("ign_done_count0", cnt_done[0], 1);
    chk("ign_done_count1", cnt_done[1], 1);
    chk("ign_bit6", int'(s_tx[0][19]), 1);
    chk("ign_bit7", int'(s_tx[0][23]), 0);
    chk("ign_idle_end", int'(s_busy[0][69]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
